// File: rtl/layer1_pkg.sv
// layer1_pkg: shared dimensions and FSM states for the layer-1 convolution sequencer.
package layer1_pkg;
    localparam int IMG_W     = 32;
    localparam int IMG_H     = 32;
    localparam int IN_CH     = 3;
    localparam int OUT_CH    = 8;
    localparam int K         = 3;
    localparam int ADDR_W    = 16;
    localparam int OUT_W     = IMG_W - K + 1;
    localparam int OUT_H     = IMG_H - K + 1;
    localparam int TAPS      = IN_CH * K * K;
    localparam int CH_PLANE  = IMG_W * IMG_H;
    localparam int OUT_PLANE = OUT_W * OUT_H;

    typedef enum logic [2:0] {
        IDLE, BIAS_RD, BIAS_LD, MAC, DRAIN, WRITE, DONE
    } state_t;
endpackage

// File: rtl/layer1_conv_sequencer_index.sv
// conv_index_gen: nested kernel/channel/pixel counters and the memory addresses derived from them.
module conv_index_gen import layer1_pkg::*; #(
    parameter int IMG_W  = layer1_pkg::IMG_W,
    parameter int IMG_H  = layer1_pkg::IMG_H,
    parameter int IN_CH  = layer1_pkg::IN_CH,
    parameter int OUT_CH = layer1_pkg::OUT_CH,
    parameter int K      = layer1_pkg::K,
    parameter int ADDR_W = layer1_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              tap_step,
    input  logic              pix_step,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic [ADDR_W-1:0] weight_addr,
    output logic [ADDR_W-1:0] bias_addr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              tap_first,
    output logic              tap_last,
    output logic              pix_last,
    output logic              oc_last
);
    localparam int OUT_W = IMG_W - K + 1;
    localparam int OUT_H = IMG_H - K + 1;
    localparam int KW = $clog2(K);
    localparam int CW = $clog2(IN_CH);
    localparam int XW = $clog2(OUT_W);
    localparam int YW = $clog2(OUT_H);
    localparam int OW = $clog2(OUT_CH);

    logic [KW-1:0] kx, ky;
    logic [CW-1:0] ic;
    logic [XW-1:0] ox;
    logic [YW-1:0] oy;
    logic [OW-1:0] oc;
    logic kx_w, ky_w, ic_w, ox_w, oy_w;

    assign kx_w      = kx == KW'(K - 1);
    assign ky_w      = ky == KW'(K - 1);
    assign ic_w      = ic == CW'(IN_CH - 1);
    assign ox_w      = ox == XW'(OUT_W - 1);
    assign oy_w      = oy == YW'(OUT_H - 1);
    assign oc_last   = oc == OW'(OUT_CH - 1);
    assign tap_first = {ic, ky, kx} == '0;
    assign tap_last  = kx_w && ky_w && ic_w;
    assign pix_last  = ox_w && oy_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || clr) begin
            kx <= '0;
            ky <= '0;
            ic <= '0;
            ox <= '0;
            oy <= '0;
            oc <= '0;
        end else begin
            if (tap_step) begin
                kx <= kx_w ? '0 : kx + KW'(1);
                if (kx_w) ky <= ky_w ? '0 : ky + KW'(1);
                if (kx_w && ky_w) ic <= ic_w ? '0 : ic + CW'(1);
            end
            if (pix_step) begin
                ox <= ox_w ? '0 : ox + XW'(1);
                if (ox_w) oy <= oy_w ? '0 : oy + YW'(1);
                if (ox_w && oy_w) oc <= oc_last ? '0 : oc + OW'(1);
            end
        end
    end

    assign pixel_addr  = ADDR_W'(int'(ic) * IMG_W * IMG_H + (int'(oy) + int'(ky)) * IMG_W + int'(ox) + int'(kx));
    assign weight_addr = ADDR_W'((int'(oc) * IN_CH + int'(ic)) * K * K + int'(ky) * K + int'(kx));
    assign bias_addr   = ADDR_W'(oc);
    assign out_addr    = ADDR_W'(int'(oc) * OUT_W * OUT_H + int'(oy) * OUT_W + int'(ox));
endmodule

// File: rtl/layer1_conv_sequencer.sv
// layer1_conv_sequencer: walks the layer-1 3x3 convolution, driving memory reads,
// MAC strobes, output commits and the completion interrupt.
module layer1_conv_sequencer import layer1_pkg::*; #(
    parameter int IMG_W  = layer1_pkg::IMG_W,
    parameter int IMG_H  = layer1_pkg::IMG_H,
    parameter int IN_CH  = layer1_pkg::IN_CH,
    parameter int OUT_CH = layer1_pkg::OUT_CH,
    parameter int K      = layer1_pkg::K,
    parameter int ADDR_W = layer1_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              layer1_input_store_done,
    input  logic              layer1_weight_store_done,
    input  logic              layer1_bias_store_done,
    input  logic              dp_ready,
    output logic              read_pixel_mem,
    output logic [ADDR_W-1:0] pixel_mem_addr,
    output logic              read_weight_mem,
    output logic [ADDR_W-1:0] weight_mem_addr,
    output logic              read_bias_mem,
    output logic [ADDR_W-1:0] bias_mem_addr,
    output logic              bias_load,
    output logic              mac_valid,
    output logic              mac_first,
    output logic              mac_last,
    output logic              out_write,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done,
    output logic              interrupr_rsgister_write_signal,
    output logic              interrupr_rsgister_data_in
);
    state_t state, state_n;
    logic clr, tap_step, pix_step, tap_first, tap_last, pix_last, oc_last;

    conv_index_gen #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .IN_CH(IN_CH),
        .OUT_CH(OUT_CH), .K(K), .ADDR_W(ADDR_W)
    ) u_idx (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .tap_step(tap_step),
        .pix_step(pix_step),
        .pixel_addr(pixel_mem_addr),
        .weight_addr(weight_mem_addr),
        .bias_addr(bias_mem_addr),
        .out_addr(out_addr),
        .tap_first(tap_first),
        .tap_last(tap_last),
        .pix_last(pix_last),
        .oc_last(oc_last)
    );

    // Memory data returns one cycle after the read, so the MAC strobes trail the reads by one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mac_valid <= 1'b0;
            mac_first <= 1'b0;
            mac_last  <= 1'b0;
        end else begin
            state     <= state_n;
            mac_valid <= tap_step;
            mac_first <= tap_step && tap_first;
            mac_last  <= tap_step && tap_last;
        end
    end

    always_comb begin
        state_n       = state;
        clr           = 1'b0;
        tap_step      = 1'b0;
        pix_step      = 1'b0;
        read_bias_mem = 1'b0;
        bias_load     = 1'b0;
        out_write     = 1'b0;
        done          = 1'b0;
        case (state)
            IDLE: if (start && layer1_input_store_done && layer1_weight_store_done && layer1_bias_store_done) begin
                clr     = 1'b1;
                state_n = BIAS_RD;
            end
            BIAS_RD: begin
                read_bias_mem = 1'b1;
                state_n       = BIAS_LD;
            end
            BIAS_LD: begin
                bias_load = 1'b1;
                state_n   = MAC;
            end
            MAC: begin
                tap_step = dp_ready;
                state_n  = dp_ready && tap_last ? DRAIN : MAC;
            end
            DRAIN: state_n = WRITE;
            WRITE: begin
                out_write = 1'b1;
                pix_step  = 1'b1;
                state_n   = !pix_last ? MAC : !oc_last ? BIAS_RD : DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign read_pixel_mem                  = tap_step;
    assign read_weight_mem                 = tap_step;
    assign busy                            = state != IDLE;
    assign interrupr_rsgister_write_signal = done;
    assign interrupr_rsgister_data_in      = done;
endmodule

// File: tb/tb_layer1_conv_sequencer.sv
// tb_layer1_conv_sequencer: directed checks of the full-size sequencer plus a 4x4-image
// instance that reaches the last channel and completion within a short run.
module tb_layer1_conv_sequencer;
    logic clk = 1'b0;
    logic rst, rst_s, start, start_s, i_done, w_done, b_done, dp_ready;

    logic        read_pixel_mem, read_weight_mem, read_bias_mem, bias_load;
    logic        mac_valid, mac_first, mac_last, out_write, busy, done, irq_w, irq_d;
    logic [15:0] pixel_mem_addr, weight_mem_addr, bias_mem_addr, out_addr;

    logic        read_pixel_mem_s, read_weight_mem_s, read_bias_mem_s, bias_load_s;
    logic        mac_valid_s, mac_first_s, mac_last_s, out_write_s, busy_s, done_s, irq_w_s, irq_d_s;
    logic [15:0] pixel_mem_addr_s, weight_mem_addr_s, bias_mem_addr_s, out_addr_s;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    layer1_conv_sequencer dut (
        .clk(clk), .rst(rst), .start(start),
        .layer1_input_store_done(i_done), .layer1_weight_store_done(w_done),
        .layer1_bias_store_done(b_done), .dp_ready(dp_ready),
        .read_pixel_mem(read_pixel_mem), .pixel_mem_addr(pixel_mem_addr),
        .read_weight_mem(read_weight_mem), .weight_mem_addr(weight_mem_addr),
        .read_bias_mem(read_bias_mem), .bias_mem_addr(bias_mem_addr),
        .bias_load(bias_load), .mac_valid(mac_valid), .mac_first(mac_first),
        .mac_last(mac_last), .out_write(out_write), .out_addr(out_addr),
        .busy(busy), .done(done),
        .interrupr_rsgister_write_signal(irq_w), .interrupr_rsgister_data_in(irq_d)
    );

    layer1_conv_sequencer #(.IMG_W(4), .IMG_H(4)) dut_s (
        .clk(clk), .rst(rst_s), .start(start_s),
        .layer1_input_store_done(i_done), .layer1_weight_store_done(w_done),
        .layer1_bias_store_done(b_done), .dp_ready(dp_ready),
        .read_pixel_mem(read_pixel_mem_s), .pixel_mem_addr(pixel_mem_addr_s),
        .read_weight_mem(read_weight_mem_s), .weight_mem_addr(weight_mem_addr_s),
        .read_bias_mem(read_bias_mem_s), .bias_mem_addr(bias_mem_addr_s),
        .bias_load(bias_load_s), .mac_valid(mac_valid_s), .mac_first(mac_first_s),
        .mac_last(mac_last_s), .out_write(out_write_s), .out_addr(out_addr_s),
        .busy(busy_s), .done(done_s),
        .interrupr_rsgister_write_signal(irq_w_s), .interrupr_rsgister_data_in(irq_d_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int n, nmv, first_mv, last_mv, fc, lc, rd_cnt;
        logic hold_ok;
        rst = 1'b1; rst_s = 1'b1; start = 1'b0; start_s = 1'b0;
        i_done = 1'b1; w_done = 1'b0; b_done = 1'b1; dp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_strobes", {read_pixel_mem, read_weight_mem, read_bias_mem, bias_load, mac_valid, mac_first,
                              mac_last, out_write, busy, done, irq_w, irq_d}, 0);
        check("rst_addrs", pixel_mem_addr | weight_mem_addr | bias_mem_addr | out_addr, 0);
        rst = 1'b0; rst_s = 1'b0;
        step();

        start = 1'b1;
        step();
        start = 1'b0;
        check("gate_busy", busy, 0);
        check("gate_read", read_bias_mem | read_pixel_mem, 0);
        step();
        check("gate_busy_after", busy, 0);

        w_done = 1'b1;
        start = 1'b1;
        cyc = 0;
        step();
        start = 1'b0;
        check("c1_read_bias", read_bias_mem, 1);
        check("c1_bias_addr", bias_mem_addr, 0);
        check("c1_busy", busy, 1);
        step();
        check("c2_bias_load", bias_load, 1);

        nmv = 0; first_mv = -1; last_mv = -1; fc = -1; lc = -1;
        for (int c = 3; c <= 31; c++) begin
            step();
            if (mac_valid) begin
                nmv++;
                if (first_mv < 0) first_mv = c;
                last_mv = c;
            end
            if (mac_first) fc = c;
            if (mac_last) lc = c;
            if (c == 3) begin
                check("tap0_read", read_pixel_mem & read_weight_mem, 1);
                check("tap0_pix", pixel_mem_addr, 0);
                check("tap0_wgt", weight_mem_addr, 0);
            end
            if (c == 29) begin
                check("tap26_pix", pixel_mem_addr, 2114);
                check("tap26_wgt", weight_mem_addr, 26);
            end
            if (c == 31) begin
                check("px0_write", out_write, 1);
                check("px0_addr", out_addr, 0);
            end
        end
        check("mv_count", nmv, 27);
        check("mv_first_cyc", first_mv, 4);
        check("mv_last_cyc", last_mv, 30);
        check("mac_first_cyc", fc, 4);
        check("mac_last_cyc", lc, 30);

        while (cyc < 41) step();
        check("tap9_pix", pixel_mem_addr, 1025);
        step();
        dp_ready = 1'b0;
        #1;
        rd_cnt = 0; nmv = 0; hold_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rd_cnt += int'(read_pixel_mem | read_weight_mem);
            hold_ok &= (pixel_mem_addr == 16'd1026) && (weight_mem_addr == 16'd10);
            nmv += int'(mac_valid);
            if (i < 4) step();
        end
        check("stall_reads", rd_cnt, 0);
        check("stall_hold", hold_ok, 1);
        check("stall_mv", nmv, 1);
        step();
        dp_ready = 1'b1;
        #1;
        check("resume_read", read_pixel_mem, 1);
        check("resume_pix", pixel_mem_addr, 1026);
        while (cyc < 60) step();
        check("stall_no_early_write", out_write, 0);
        while (cyc < 65) step();
        check("stall_write", out_write, 1);
        check("stall_out_addr", out_addr, 1);

        n = 0;
        while (!(out_write && out_addr == 16'd899) && n < 30000) begin step(); n++; end
        check("ch0_end_reached", n < 30000, 1);
        step();
        check("ch1_bias_rd", read_bias_mem, 1);
        check("ch1_bias_addr", bias_mem_addr, 1);
        step();
        step();
        check("ch1_tap0_wgt", weight_mem_addr, 27);
        check("ch1_tap0_pix", pixel_mem_addr, 0);
        n = 0;
        while (!out_write && n < 40) begin step(); n++; end
        check("ch1_write_reached", n < 40, 1);
        check("ch1_out_addr", out_addr, 900);
        rst = 1'b1;
        #1;
        check("big_rst_busy", busy, 0);

        start_s = 1'b1;
        step();
        start_s = 1'b0;
        check("s_busy", busy_s, 1);
        i_done = 1'b0; w_done = 1'b0; b_done = 1'b0;
        step();
        start_s = 1'b1;
        step();
        start_s = 1'b0;
        n = 0;
        while (!(out_write_s && out_addr_s == 16'd30) && n < 2000) begin step(); n++; end
        check("s_px30_reached", n < 2000, 1);
        step();
        check("s_last_pix", pixel_mem_addr_s, 5);
        check("s_last_wgt", weight_mem_addr_s, 189);
        n = 0;
        while (!out_write_s && n < 40) begin step(); n++; end
        check("s_last_write_reached", n < 40, 1);
        check("s_last_out_addr", out_addr_s, 31);
        step();
        check("s_done", {done_s, irq_w_s, irq_d_s, busy_s}, 4'b1111);
        step();
        check("s_idle", {done_s, irq_w_s, irq_d_s, busy_s}, 0);

        i_done = 1'b1; w_done = 1'b1; b_done = 1'b1;
        start_s = 1'b1;
        step();
        start_s = 1'b0;
        n = 0;
        while (!(read_bias_mem_s && bias_mem_addr_s == 16'd3) && n < 1000) begin step(); n++; end
        check("s_oc3_reached", n < 1000, 1);
        repeat (4) step();
        check("s_oc3_mac", read_pixel_mem_s, 1);
        rst_s = 1'b1;
        #1;
        check("s_rst_strobes", {read_pixel_mem_s, read_weight_mem_s, read_bias_mem_s, bias_load_s, mac_valid_s,
                                mac_first_s, mac_last_s, out_write_s, busy_s, done_s, irq_w_s, irq_d_s}, 0);
        check("s_rst_addrs", pixel_mem_addr_s | weight_mem_addr_s | bias_mem_addr_s | out_addr_s, 0);
        rst_s = 1'b0;
        step();
        start_s = 1'b1;
        step();
        start_s = 1'b0;
        check("s_restart_bias", {read_bias_mem_s, bias_mem_addr_s}, {1'b1, 16'd0});
        step();
        step();
        check("s_restart_tap0", {read_pixel_mem_s, pixel_mem_addr_s, weight_mem_addr_s}, {1'b1, 16'd0, 16'd0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
